// File: rtl/instr_encoder.sv
// RV32I field packer: encodes decoded fields plus a signed immediate into a
// 32-bit word tagged with a sequential address, one registered stage.
//
// Ports:
//   clk, rst (sync, active-high)
//   in_valid/in_ready + opcode, rd, rs1, rs2, funct3, funct7, imm : bundle in
//   addr_load, addr_in : reload the address counter
//   out_valid/out_ready + out_instr, out_addr : encoded word out
//   err, err_code : one-cycle pulse and cause for a rejected bundle
//   instr_count : number of legal words accepted
module instr_encoder #(
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [15:0]       instr_count
);

  localparam logic [1:0] E_NONE  = 2'b00;
  localparam logic [1:0] E_OP    = 2'b01;
  localparam logic [1:0] E_RANGE = 2'b10;
  localparam logic [1:0] E_ALIGN = 2'b11;

  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_instr_q, out_instr_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       cnt_q, cnt_d;

  logic is_i, is_s, is_b, is_u, is_j, is_r;
  logic fits12, fits13, fits21;
  logic [31:0] word;
  logic [1:0]  code;
  logic accept;

  assign is_i = (opcode == 7'b0000011) || (opcode == 7'b0010011)
             || (opcode == 7'b1100111);
  assign is_s = (opcode == 7'b0100011);
  assign is_b = (opcode == 7'b1100011);
  assign is_u = (opcode == 7'b0110111) || (opcode == 7'b0010111);
  assign is_j = (opcode == 7'b1101111);
  assign is_r = (opcode == 7'b0110011);

  // A value fits an N-bit signed field when every bit above the sign
  // position matches the sign bit.
  assign fits12 = (&imm[31:11]) || !(|imm[31:11]);
  assign fits13 = (&imm[31:12]) || !(|imm[31:12]);
  assign fits21 = (&imm[31:20]) || !(|imm[31:20]);

  always_comb begin
    word = '0;
    code = E_NONE;
    unique case (1'b1)
      is_i: begin
        word = {imm[11:0], rs1, funct3, rd, opcode};
        if (!fits12) code = E_RANGE;
      end
      is_s: begin
        word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        if (!fits12) code = E_RANGE;
      end
      is_b: begin
        word = {imm[12], imm[10:5], rs2, rs1, funct3,
                imm[4:1], imm[11], opcode};
        if (!fits13)     code = E_RANGE;
        else if (imm[0]) code = E_ALIGN;
      end
      is_u: begin
        word = {imm[31:12], rd, opcode};
        if (|imm[11:0]) code = E_ALIGN;
      end
      is_j: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        if (!fits21)     code = E_RANGE;
        else if (imm[0]) code = E_ALIGN;
      end
      is_r: begin
        word = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      default: code = E_OP;
    endcase
  end

  assign in_ready = !addr_load && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_addr_d  = out_addr_q;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (addr_load) begin
      addr_d = addr_in;
    end else if (accept) begin
      err_code_d = code;
      if (code == E_NONE) begin
        out_valid_d = 1'b1;
        out_instr_d = word;
        out_addr_d  = addr_q;
        addr_d      = addr_q + ADDR_W'(4);
        cnt_d       = cnt_q + 16'd1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_addr_q  <= '0;
      err_q       <= 1'b0;
      err_code_q  <= E_NONE;
      addr_q      <= BASE_ADDR;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_addr_q  <= out_addr_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_instr   = out_instr_q;
  assign out_addr    = out_addr_q;
  assign err         = err_q;
  assign err_code    = err_code_q;
  assign instr_count = cnt_q;

endmodule
